// File: rtl/seq_signed_or_unsigned_mul_pkg.sv
// Shared types for the iterative signed/unsigned multiplier.
// Latency: not applicable (types and helpers only).
// Backpressure: not applicable.
package mul_pkg;

    // Controller states; the encoding is fixed so waveform decodes stay stable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The iteration counter must be able to hold 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_signed_or_unsigned_mul_twos_abs.sv
// Conditional two's-complement magnitude of an n-bit operand.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module twos_abs #(
    parameter int n = 8
) (
    input  logic [n-1:0] x,
    input  logic         en,
    output logic [n-1:0] mag
);

    // The most negative value maps onto 2^(n-1), which still fits as an
    // unsigned n-bit magnitude, so no extra bit is needed.
    assign mag = (en && x[n-1]) ? (~x + n'(1)) : x;

endmodule

// File: rtl/seq_signed_or_unsigned_mul.sv
// Shift-add multiplier, n x n -> 2n bits, signed or unsigned per transaction.
// Latency: n cycles from the acceptance edge to down_valid; one product per n+2 cycles.
// Backpressure: up_ready only in IDLE; res/down_valid hold in DONE until down_ready.
module seq_signed_or_unsigned_mul
    import mul_pkg::*;
#(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           up_valid,
    output logic           up_ready,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    input  logic           signed_mul,
    output logic           down_valid,
    input  logic           down_ready,
    output logic [2*n-1:0] res
);

    localparam int CW = cnt_width(n);

    state_t           state;
    logic [2*n-1:0]   mcand;
    logic [2*n-1:0]   acc;
    logic [2*n-1:0]   acc_sum;
    logic [2*n-1:0]   acc_neg;
    logic [n-1:0]     mplier;
    logic [n-1:0]     a_mag;
    logic [n-1:0]     b_mag;
    logic             neg;
    logic             last_iter;
    logic [CW-1:0]    cnt;

    // Operands are reduced to magnitudes up front so the core loop is unsigned.
    twos_abs #(.n(n)) u_abs_a (
        .x   (a),
        .en  (signed_mul),
        .mag (a_mag)
    );

    twos_abs #(.n(n)) u_abs_b (
        .x   (b),
        .en  (signed_mul),
        .mag (b_mag)
    );

    // Handshake outputs depend on registered state only.
    assign up_ready   = (state == IDLE);
    assign down_valid = (state == DONE);

    // Single shared adder: the multiplicand is pre-shifted, so no bit index is needed.
    assign acc_sum   = acc + (mplier[0] ? mcand : '0);
    assign acc_neg   = ~acc_sum + (2*n)'(1);
    assign last_iter = (cnt == CW'(n - 1));

    // Controller and datapath; a reset at any point drops the transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            res    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (up_valid) begin
                        mcand  <= {{n{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= signed_mul & (a[n-1] ^ b[n-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        // Negating a zero magnitude yields zero, so no negative zero.
                        res   <= neg ? acc_neg : acc_sum;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (down_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_or_unsigned_mul.sv
module tb_seq_signed_or_unsigned_mul;

    localparam int N      = 8;
    localparam int NRAND  = 1000;
    localparam int BOUND  = 50;

    logic           clk;
    logic           rst;
    logic           up_valid;
    logic           up_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           signed_mul;
    logic           down_valid;
    logic           down_ready;
    logic [2*N-1:0] res;

    int errors = 0;
    int checks = 0;

    seq_signed_or_unsigned_mul #(.n(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .a          (a),
        .b          (b),
        .signed_mul (signed_mul),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .res        (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product from plain integer arithmetic.
    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                                               input logic s);
        int p;
        if (s) p = int'($signed(x)) * int'($signed(y));
        else   p = int'(x) * int'(y);
        return p[2*N-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one transaction; returns the product and cycles from acceptance to down_valid.
    task automatic run_one(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                           output logic [2*N-1:0] r, output int lat);
        int guard;
        a = x; b = y; signed_mul = s; up_valid = 1'b1;
        guard = 0;
        while (!up_ready && guard < BOUND) begin
            tick();
            guard++;
        end
        tick();
        up_valid = 1'b0;
        lat = 0;
        while (!down_valid && lat < BOUND) begin
            tick();
            lat++;
        end
        r = res;
        down_ready = 1'b1;
        tick();
        down_ready = 1'b0;
    endtask

    initial begin
        logic [2*N-1:0] r;
        logic [2*N-1:0] held;
        logic [2*N-1:0] exp_q[$];
        logic [2*N-1:0] e;
        int lat;
        int seen;
        int sent;
        int recv;
        int cyc;
        logic acc_now;

        rst = 1'b1; up_valid = 1'b0; down_ready = 1'b0;
        a = '0; b = '0; signed_mul = 1'b0;
        repeat (3) tick();
        chk("reset_up_ready", 32'(up_ready), 32'd1);
        chk("reset_down_valid", 32'(down_valid), 32'd0);
        chk("reset_res", 32'(res), 32'h0);
        rst = 1'b0;
        tick();

        run_one(8'h03, 8'h05, 1'b0, r, lat);
        chk("u_3x5", 32'(r), 32'h000F);
        chk("latency", 32'(lat), 32'd8);

        run_one(8'hFF, 8'hFF, 1'b1, r, lat);
        chk("s_ffxff", 32'(r), 32'h0001);
        run_one(8'hFF, 8'hFF, 1'b0, r, lat);
        chk("u_ffxff", 32'(r), 32'hFE01);
        run_one(8'h80, 8'h80, 1'b1, r, lat);
        chk("s_80x80", 32'(r), 32'h4000);
        run_one(8'h80, 8'h7F, 1'b1, r, lat);
        chk("s_80x7f", 32'(r), 32'hC080);
        run_one(8'h00, 8'h80, 1'b1, r, lat);
        chk("s_00x80", 32'(r), 32'h0000);
        chk("zero_latency", 32'(lat), 32'd8);

        // Backpressure: hold DONE for five cycles while a new request is pending.
        a = 8'h0C; b = 8'h0B; signed_mul = 1'b0; up_valid = 1'b1;
        tick();
        a = 8'h11; b = 8'h22; signed_mul = 1'b1;
        lat = 0;
        while (!down_valid && lat < BOUND) begin
            tick();
            lat++;
        end
        held = 16'h0084;
        for (int k = 0; k < 5; k++) begin
            chk("bp_res", 32'(res), 32'(held));
            chk("bp_down_valid", 32'(down_valid), 32'd1);
            chk("bp_up_ready", 32'(up_ready), 32'd0);
            tick();
        end
        down_ready = 1'b1;
        tick();
        up_valid = 1'b0;
        down_ready = 1'b0;
        chk("bp_release_up_ready", 32'(up_ready), 32'd1);
        chk("bp_release_down_valid", 32'(down_valid), 32'd0);
        tick();
        chk("bp_no_restart", 32'(up_ready), 32'd1);

        // Asynchronous reset during the fourth BUSY iteration.
        a = 8'h55; b = 8'h33; signed_mul = 1'b0; up_valid = 1'b1;
        tick();
        up_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("arst_up_ready", 32'(up_ready), 32'd1);
        chk("arst_down_valid", 32'(down_valid), 32'd0);
        chk("arst_res", 32'(res), 32'h0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (down_valid) seen++;
            tick();
        end
        chk("arst_no_result", 32'(seen), 32'd0);
        run_one(8'h02, 8'h03, 1'b0, r, lat);
        chk("post_reset_2x3", 32'(r), 32'h0006);

        // Random stream: up_valid held, down_ready random, scoreboard in order.
        sent = 0; recv = 0; cyc = 0;
        a = 8'($urandom); b = 8'($urandom); signed_mul = 1'($urandom);
        while (recv < NRAND && cyc < NRAND * 40) begin
            up_valid   = (sent < NRAND);
            down_ready = 1'($urandom_range(0, 1));
            acc_now    = up_valid && up_ready;
            if (acc_now) exp_q.push_back(ref_mul(a, b, signed_mul));
            if (down_valid && down_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_extra_result", 32'(res), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_res", 32'(res), 32'(e));
                end
                recv++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                sent++;
                a = 8'($urandom); b = 8'($urandom); signed_mul = 1'($urandom);
            end
        end
        up_valid = 1'b0;
        down_ready = 1'b0;
        chk("rand_received", 32'(recv), 32'(NRAND));
        chk("rand_pending", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_signed_or_unsigned_mul.md
# seq_signed_or_unsigned_mul

Iterative (shift-add) multiplier for two n-bit operands producing a 2n-bit product, signed or unsigned per transaction as selected by a mode bit captured with the operands. It is the area-lean sequential successor of the combinational signed/unsigned multiplier. It uses one adder for n cycles instead of an n×n array. It sits in the arithmetic section behind a valid/ready stream interface on both sides.

## Interface
- n, default 8: operand width in bits; legal n ≥ 2; product width 2n.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- up_valid  input  1  operand transaction present.
- up_ready  output  1  block can accept a transaction; high only in IDLE.
- a, b  input  n  operands, raw bit patterns.
- signed_mul  input  1  1 = treat a, b as two's complement; 0 = unsigned; sampled with a, b.
- down_valid  output  1  res holds a completed product.
- down_ready  input  1  consumer accepts res.
- res  output  2n  product; meaningful only while down_valid = 1.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: up_ready = 1. On up_valid & up_ready, capture operands and go to BUSY. Signed mode captures |a|, |b| (n-bit magnitudes) and neg = a[n-1] ^ b[n-1]. Unsigned mode captures a, b as-is and sets neg = 0. Clear accumulator and set iteration counter to 0.
- BUSY: each cycle, if multiplier LSB = 1, add multiplicand into the accumulator at the current bit position. Shift and increment the counter. After the n-th iteration, go to DONE. Res = accumulator, or its two's complement negation (~acc + 1, 2n bits) when neg = 1. Res is registered on the BUSY→DONE edge.
- DONE: down_valid = 1, res stable. On down_ready, go to IDLE.
- up_valid in BUSY/DONE is ignored (up_ready = 0); the upstream must hold its transaction.
- Magnitude of −2^(n−1) is 2^(n−1), representable in n unsigned bits. (−2^(n−1))² = 2^(2n−2) fits the signed 2n result. No overflow is possible in either mode.
- Zero operand: full n iterations still run; res = 0 with no negative zero.
- Reset: state = IDLE, counter = 0, accumulator = 0, res = 0, down_valid = 0, up_ready = 1 (combinational from state). A reset mid-BUSY or mid-DONE discards the transaction; no result is emitted.

## Timing
- Acceptance edge = E. BUSY occupies the n cycles after E. down_valid rises in the cycle after edge E+n, giving latency n cycles from acceptance edge to down_valid.
- Leaving DONE on edge D (down_valid & down_ready): up_ready = 1 in the following cycle. The next acceptance is at D+1 at the earliest.
- Maximum throughput: one product per n+2 cycles.
- down_valid and res hold unchanged for any number of down_ready = 0 cycles.
- up_ready and down_valid are decoded from registered state only, with no combinational path from up_valid or down_ready.

## Structure
- Package mul_pkg: state enum type (IDLE, BUSY, DONE), localparam helper for counter width $clog2(n+1).
- One natural sub-module: twos_abs (n-bit conditional two's-complement magnitude). It is instantiated twice, for a and b. The final conditional negation is inline.
- Datapath regs: multiplicand (2n), multiplier (n), accumulator (2n), neg, counter, res.

## Test plan
All cases use n = 8.
- Unsigned 0x03 × 0x05, signed_mul = 0 → res = 0x000F; down_valid rises exactly 8 cycles after acceptance edge.
- 0xFF × 0xFF: signed_mul = 1 → 0x0001; signed_mul = 0 → 0xFE01.
- Signed corners: 0x80 × 0x80 → 0x4000; 0x80 × 0x7F → 0xC080; 0x00 × 0x80 → 0x0000.
- Backpressure: down_ready = 0 for 5 cycles after down_valid. Res and down_valid hold, up_ready = 0, and a new up_valid is ignored. Raising down_ready gives up_ready = 1 next cycle.
- Reset asserted asynchronously at BUSY iteration 4. All outputs return to reset values immediately, and no down_valid follows. A new 0x02 × 0x03 transaction then yields 0x0006.
- Randomised back-to-back stream of 1000 operand/mode triples compared against a reference model. Up_valid is held high and down_ready toggles randomly. No result is lost or duplicated.
